// File: rtl/dot_prod_seq.sv
// dot_prod_seq: sequencer that feeds a sequential multiplier one operand pair at a
// time and accumulates the signed products into a dot product.
//
// Ports:
//   clk_i        single clock, rising edge
//   reset_ni     asynchronous, active-low reset
//   start_i      begin a new dot product (sampled only when idle)
//   len_i        number of operand pairs, unsigned, sampled with start_i
//   in_valid_i   operand pair valid
//   in_ready_o   block can take a pair
//   in_a_i       signed operand a
//   in_b_i       signed operand b
//   mul_a_o      registered operand a to the multiplier
//   mul_b_o      registered operand b to the multiplier
//   mul_start_o  one-cycle start pulse to the multiplier
//   mul_p_i      signed product from the multiplier
//   mul_rdy_i    multiplier result valid
//   acc_o        signed running / final sum
//   busy_o       high whenever not idle
//   done_o       one-cycle pulse when acc_o is final
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start_i; acc_o holds the last result
// FETCH  | in_ready_o high, waiting for an operand pair
// ISSUE  | mul_start_o pulse; operands already on mul_a_o/mul_b_o
// WAIT   | operands held until mul_rdy_i, then accumulate
// DONE   | done_o pulse, acc_o final
module dot_prod_seq #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int ACC_W = 2*WIDTH + LEN_W
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 start_i,
    input  logic [LEN_W-1:0]     len_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     in_a_i,
    input  logic [WIDTH-1:0]     in_b_i,
    output logic [WIDTH-1:0]     mul_a_o,
    output logic [WIDTH-1:0]     mul_b_o,
    output logic                 mul_start_o,
    input  logic [2*WIDTH-1:0]   mul_p_i,
    input  logic                 mul_rdy_i,
    output logic [ACC_W-1:0]     acc_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int EXT_W = ACC_W - 2*WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic               mul_start_q, mul_start_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [ACC_W-1:0]   prod_ext;

    assign prod_ext = {{EXT_W{mul_p_i[2*WIDTH-1]}}, mul_p_i};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    acc_d   = '0;
                    count_d = len_i;
                    state_d = (len_i == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (in_valid_i && in_ready_q) begin
                    mul_a_d = in_a_i;
                    mul_b_d = in_b_i;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_rdy_i) begin
                    acc_d   = acc_q + prod_ext;
                    count_d = count_q - LEN_W'(1);
                    state_d = (count_q == LEN_W'(1)) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        in_ready_d  = (state_d == S_FETCH);
        mul_start_d = (state_d == S_ISSUE);
        done_d      = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_start_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_start_q <= mul_start_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign mul_a_o     = mul_a_q;
    assign mul_b_o     = mul_b_q;
    assign mul_start_o = mul_start_q;
    assign acc_o       = acc_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_dot_prod_seq.sv
module tb_dot_prod_seq;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;
    localparam int ACC_W = 2*WIDTH + LEN_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                start_i = 1'b0;
    logic [LEN_W-1:0]    len_i = '0;
    logic                in_valid_i = 1'b0;
    logic                in_ready_o;
    logic [WIDTH-1:0]    in_a_i = '0;
    logic [WIDTH-1:0]    in_b_i = '0;
    logic [WIDTH-1:0]    mul_a_o;
    logic [WIDTH-1:0]    mul_b_o;
    logic                mul_start_o;
    logic [2*WIDTH-1:0]  mul_p_i;
    logic                mul_rdy_i;
    logic [ACC_W-1:0]    acc_o;
    logic                busy_o;
    logic                done_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dot_prod_seq #(.WIDTH(WIDTH), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clk_i       (clk),
        .reset_ni    (rst_n),
        .start_i     (start_i),
        .len_i       (len_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_a_i      (in_a_i),
        .in_b_i      (in_b_i),
        .mul_a_o     (mul_a_o),
        .mul_b_o     (mul_b_o),
        .mul_start_o (mul_start_o),
        .mul_p_i     (mul_p_i),
        .mul_rdy_i   (mul_rdy_i),
        .acc_o       (acc_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Multiplier stand-in: start clears rdy, product appears after a variable delay
    // and is held with rdy high until the next start.
    int          m_cnt = 0;
    int          m_nstart = 0;
    logic [WIDTH-1:0] m_opa = '0, m_opb = '0;
    logic        m_rdy = 1'b0;
    logic [2*WIDTH-1:0] m_p = '0;
    assign mul_rdy_i = m_rdy;
    assign mul_p_i   = m_p;

    always @(posedge clk) begin
        if (mul_start_o) begin
            m_rdy    <= 1'b0;
            m_opa    <= mul_a_o;
            m_opb    <= mul_b_o;
            m_cnt    <= 1 + (m_nstart % 3);
            m_nstart <= m_nstart + 1;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_rdy <= 1'b1;
                m_p   <= 16'($signed(m_opa) * $signed(m_opb));
            end
        end
    end

    // Behavioural model of the sequencer seen from outside: a run is active from the
    // accepted start until its done cycle; it wants pairs until len have been taken;
    // each taken pair must be issued next cycle and its product summed once ready.
    bit  md_active, md_want, md_waiting, md_issue_next, md_done_next;
    int  md_len, md_taken, md_acc, md_a, md_b;
    int  n_starts_seen = 0;

    always @(negedge clk) begin
        bit issue_now, done_now;
        if (!rst_n) begin
            md_active = 0; md_want = 0; md_waiting = 0;
            md_issue_next = 0; md_done_next = 0;
            md_len = 0; md_taken = 0; md_acc = 0;
        end else begin
            chk("busy", busy_o, md_active);
            chk("in_ready", in_ready_o, md_want);
            chk("mul_start", mul_start_o, md_issue_next);
            chk("done", done_o, md_done_next);
            chk("acc", $signed(acc_o), md_acc);
            if (md_waiting || md_issue_next) begin
                chk("mul_a_hold", $signed(mul_a_o), md_a);
                chk("mul_b_hold", $signed(mul_b_o), md_b);
            end
            if (mul_start_o) n_starts_seen++;

            issue_now = md_issue_next;
            done_now  = md_done_next;
            md_issue_next = 0;
            md_done_next  = 0;
            if (!md_active && start_i) begin
                md_active = 1;
                md_len    = int'(len_i);
                md_taken  = 0;
                md_acc    = 0;
                if (md_len == 0) md_done_next = 1;
                else md_want = 1;
            end else if (md_want && in_valid_i) begin
                md_a = int'($signed(in_a_i));
                md_b = int'($signed(in_b_i));
                md_want = 0;
                md_taken++;
                md_issue_next = 1;
            end else if (md_waiting && mul_rdy_i) begin
                md_acc += md_a * md_b;
                md_waiting = 0;
                if (md_taken == md_len) md_done_next = 1;
                else md_want = 1;
            end
            if (issue_now) md_waiting = 1;
            if (done_now) md_active = 0;
        end
    end

    task automatic start_run(input int n);
        @(posedge clk); #1;
        start_i = 1'b1;
        len_i   = LEN_W'(n);
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic feed_pair(input int a, input int b);
        bit ok = 0;
        in_a_i = WIDTH'(a);
        in_b_i = WIDTH'(b);
        in_valid_i = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready_o) begin ok = 1; break; end
        end
        if (!ok) chk("handshake_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input string nm, input int exp_lit);
        bit ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done_o) begin ok = 1; break; end
        end
        if (!ok) chk({nm, "_done_timeout"}, 0, 1);
        else chk({nm, "_final_acc"}, $signed(acc_o), exp_lit);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_acc"}, acc_o, 0);
        chk({nm, "_mul_a"}, mul_a_o, 0);
        chk({nm, "_mul_b"}, mul_b_o, 0);
        chk({nm, "_mul_start"}, mul_start_o, 0);
        chk({nm, "_in_ready"}, in_ready_o, 0);
        chk({nm, "_busy"}, busy_o, 0);
        chk({nm, "_done"}, done_o, 0);
    endtask

    initial begin
        int s0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // (1,2),(3,4),(5,6), valid left high so stale pairs sit outside FETCH
        s0 = n_starts_seen;
        start_run(3);
        feed_pair(1, 2);
        feed_pair(3, 4);
        feed_pair(5, 6);
        wait_done("t1", 44);
        in_valid_i = 1'b0;
        chk("t1_starts", n_starts_seen - s0, 3);

        start_run(3);
        feed_pair(-10, 2);
        feed_pair(10, -2);
        feed_pair(-1, -1);
        in_valid_i = 1'b0;
        wait_done("t2", -39);

        start_run(15);
        for (int i = 0; i < 15; i++) feed_pair(-128, -128);
        in_valid_i = 1'b0;
        wait_done("t3", 245760);

        // len=0 straight to done, nothing issued
        s0 = n_starts_seen;
        start_run(0);
        wait_done("t4", 0);
        chk("t4_starts", n_starts_seen - s0, 0);

        // gap in valid while fetching, with a stray start
        s0 = n_starts_seen;
        start_run(2);
        feed_pair(7, 7);
        in_valid_i = 1'b0;
        for (int k = 0; k < 50 && !in_ready_o; k++) @(negedge clk);
        @(posedge clk); #1;
        start_i = 1'b1; len_i = LEN_W'(9);
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("t5_gap_ready", in_ready_o, 1);
        feed_pair(0, 5);
        in_valid_i = 1'b0;
        wait_done("t5", 49);
        chk("t5_starts", n_starts_seen - s0, 2);

        // abort during WAIT of second pair
        start_run(4);
        feed_pair(1, 1);
        feed_pair(2, 2);
        in_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_wait", busy_o && !in_ready_o && !mul_start_o, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;

        start_run(1);
        feed_pair(3, -3);
        in_valid_i = 1'b0;
        wait_done("t7", -9);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_prod_seq.md
# dot_prod_seq

Sequencer that sits directly upstream of the sequential multiplier `seq_mult` and also consumes its result. It accepts a stream of signed operand pairs through a valid/ready handshake. For each pair it issues one multiply using a one-cycle start pulse on the multiplier's `reset` input, waits for `rdy`, and accumulates the product. After `len` pairs it presents the signed dot product with a one-cycle `done` pulse.

## Interface
- `WIDTH`, 8, operand width; must match the multiplier's `width`.
- `LEN_W`, 4, width of the pair count; vector length is 0 to 2^LEN_W−1.
- `ACC_W`, 2*WIDTH+LEN_W, accumulator width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `start`  in  1  begin a new dot product; sampled only in IDLE.
- `len`  in  LEN_W  number of pairs, unsigned; sampled with `start`.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can take a pair.
- `in_a`, `in_b`  in  WIDTH  signed operands.
- `mul_a`, `mul_b`  out  WIDTH  registered operands; drive the multiplier's `a`/`b`.
- `mul_start`  out  1  one-cycle high pulse; drives the multiplier's `reset`.
- `mul_p`  in  2*WIDTH  signed product from the multiplier.
- `mul_rdy`  in  1  multiplier result valid.
- `acc`  out  ACC_W  signed running / final sum.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when `acc` is final.

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, DONE.
- **Reset values:** state=IDLE, `acc`=0, `mul_a`=`mul_b`=0, `mul_start`=0, `in_ready`=0, `busy`=0, `done`=0, count=0.
- **IDLE:** when `start`=1, clear `acc` and load count=`len`.
  - `len`=0: go to DONE.
  - Otherwise: go to FETCH.
- **FETCH:** `in_ready`=1. When `in_valid` && `in_ready`, latch `in_a`/`in_b` into `mul_a`/`mul_b` and go to ISSUE. With `in_valid`=0, stay in FETCH indefinitely.
- **ISSUE:** `mul_start`=1 for exactly this cycle; `mul_a`/`mul_b` stay stable. Next state is WAIT.
- **WAIT:** `mul_a`/`mul_b` are held. When `mul_rdy`=1:
  - `acc` ← `acc` + sign-extended `mul_p`.
  - count ← count−1.
  - count becomes 0: go to DONE. Otherwise: go to FETCH.
- **DONE:** `done`=1, `acc` is stable. Next state is IDLE.
- `acc` holds its final value in IDLE until the next accepted `start`.
- **Arithmetic:** two's complement throughout. `ACC_W` covers the worst case (2^LEN_W−1)·(−2^(WIDTH−1))², so no overflow occurs at defaults. Any overflow under other parameters wraps modulo 2^ACC_W with no flag.
- **Boundary conditions:**
  - `start` outside IDLE is ignored.
  - `in_valid` outside FETCH is ignored and not consumed.
  - `mul_rdy` outside WAIT is ignored.
  - `reset` asserted mid-operation aborts immediately. Outputs take their reset values, including `mul_start`=0; the partial `acc` is lost.

## Timing
- All outputs are registered.
- Required multiplier behaviour: it clears `rdy` on the edge that samples `mul_start`=1. It then holds `p` stable while `rdy`=1 until its next start.
- Per pair, with `in_valid` held high: 1 FETCH + 1 ISSUE + M WAIT cycles, where M is the number of WAIT cycles up to and including the cycle in which `mul_rdy` is seen.
- `done` is high in the cycle after the edge that performs the last accumulation.
- For `len`=0, `done` is high in the cycle after `start` is sampled, with `acc`=0.
- `busy` rises the cycle after `start` is accepted and falls in the cycle after `done`.
- A new `start` is accepted at the earliest in the cycle after `done`.

## Test plan
- `len`=3, pairs (1,2),(3,4),(5,6) with `in_valid` held high → one `done` pulse, `acc`=44; exactly 3 `mul_start` pulses; `mul_a`/`mul_b` stable throughout each WAIT.
- `len`=3, pairs (−10,2),(10,−2),(−1,−1) → `acc`=−39.
- `len`=15, every pair (−128,−128) → `acc`=245760.
- `len`=0 → `done` high in the cycle after `start`, `acc`=0, no `mul_start` pulse, `in_ready` never high.
- `len`=2, pairs (7,7) then (0,5), with `in_valid` low for 4 cycles between the pairs → block stays in FETCH during the gap, `acc`=49, and `start` pulses while busy have no effect.
- Assert `reset` low during the WAIT of the second pair of a `len`=4 run → all outputs at reset values immediately. A following `len`=1 run of (3,−3) gives `acc`=−9.
